race_game_ctrl: RTL and testbench

Game controller that sits directly upstream of the seven-segment display driver. It produces the `turn`, `sum` and `correctness` signals that the driver consumes. Two players alternately enter a step value on switches and confirm it with a push button; each valid step is added to a running sum. The player whose step lands exactly on TARGET wins, and the block then freezes until reset.

---
 rtl/race_game_pkg.sv | 21 ++
 rtl/race_game_ctrl_btn_debounce.sv | 55 +++++
 rtl/race_game_ctrl.sv | 131 +++++++++++++
 tb/tb_race_game_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/race_game_pkg.sv
// race_game_pkg
//   Shared definitions for the two-player race game controller.
//   - state_t         : controller FSM states
//   - TURN_P1/TURN_P2 : the only two legal encodings of the `turn` output
//   - TARGET_DEF      : default winning sum (must fit in 8 bits)
//   - MAX_STEP_DEF    : default largest legal step (single decimal digit)
package race_game_pkg;

    typedef enum logic [1:0] {
        S_PLAY = 2'd0,
        S_EVAL = 2'd1,
        S_WIN  = 2'd2
    } state_t;

    localparam logic [3:0] TURN_P1 = 4'd1;
    localparam logic [3:0] TURN_P2 = 4'd2;

    localparam int TARGET_DEF   = 100;
    localparam int MAX_STEP_DEF = 9;

endpackage

// File: rtl/race_game_ctrl_btn_debounce.sv
// btn_debounce
//   Cleans up a raw mechanical push button.
//   The button is synchronised through two flops. The clean level follows
//   the synchronised level once it has differed for DEBOUNCE_CYCLES
//   consecutive cycles. A one-cycle press pulse marks each 0->1 change of
//   the clean level. Releases produce no pulse.
// Ports
//   clk       : system clock
//   reset     : synchronous, active-high; clears every flop
//   btn_in    : raw asynchronous button (1 = pressed)
//   level_out : debounced button level
//   press_out : one-cycle pulse, registered, on a clean rising edge
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic level_out,
    output logic press_out
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_q1;
    logic             sync_q2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q1   <= 1'b0;
            sync_q2   <= 1'b0;
            cnt       <= '0;
            level_out <= 1'b0;
            press_out <= 1'b0;
        end else begin
            sync_q1   <= btn_in;
            sync_q2   <= sync_q1;
            press_out <= 1'b0;
            // Any cycle that agrees with the clean level restarts the
            // stability window, so only an unbroken run is accepted.
            if (sync_q2 == level_out) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level_out <= sync_q2;
                cnt       <= '0;
                press_out <= sync_q2;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/race_game_ctrl.sv
// race_game_ctrl
//   Two-player race game feeding the seven-segment display driver.
//   Each accepted button press latches the step on `sw`; the following
//   cycle evaluates it against the running sum. Landing exactly on TARGET
//   wins and freezes the block until reset.
// Ports
//   clk         : system clock
//   reset       : synchronous, active-high
//   btn         : raw bouncy push button (1 = pressed)
//   sw          : 4-bit unsigned step value
//   turn        : current player, TURN_P1 or TURN_P2 (winner once over)
//   sum         : running sum, 0..TARGET
//   correctness : 0 while the last attempted step was rejected
//   game_over   : 1 once TARGET has been reached
module race_game_ctrl
    import race_game_pkg::*;
#(
    parameter int TARGET          = TARGET_DEF,
    parameter int MAX_STEP        = MAX_STEP_DEF,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn,
    input  logic [3:0] sw,
    output logic [3:0] turn,
    output logic [7:0] sum,
    output logic       correctness,
    output logic       game_over
);

    localparam logic [8:0] TARGET_W   = 9'(TARGET);
    localparam logic [8:0] MAX_STEP_W = 9'(MAX_STEP);

    logic       press;
    logic       btn_level;
    logic       take_press;

    state_t     state;
    state_t     state_nxt;

    logic [3:0] step;
    logic [3:0] step_d;
    logic [8:0] nxt;
    logic       step_ok;
    logic [3:0] turn_d;
    logic [7:0] sum_d;
    logic       corr_d;
    logic       over_d;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
        .clk      (clk),
        .reset    (reset),
        .btn_in   (btn),
        .level_out(btn_level),
        .press_out(press)
    );

    // A press pulse is only ever emitted with the clean level high.
    assign take_press = press & btn_level;

    // Nine bits so that sum + step can never wrap.
    assign nxt     = {1'b0, sum} + {5'b0, step};
    assign step_ok = (step != 4'd0) && ({5'b0, step} <= MAX_STEP_W) &&
                     (nxt <= TARGET_W);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_PLAY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_PLAY:  if (take_press) state_nxt = S_EVAL;
            S_EVAL:  state_nxt = (step_ok && nxt == TARGET_W) ? S_WIN : S_PLAY;
            S_WIN:   state_nxt = S_WIN;
            default: state_nxt = S_PLAY;
        endcase
    end

    always_comb begin
        step_d = step;
        turn_d = turn;
        sum_d  = sum;
        corr_d = correctness;
        over_d = game_over;
        case (state)
            S_PLAY: begin
                if (take_press) step_d = sw;
            end
            S_EVAL: begin
                if (step_ok) begin
                    sum_d  = nxt[7:0];
                    corr_d = 1'b1;
                    // The winner keeps the turn so the display names them.
                    if (nxt == TARGET_W) begin
                        over_d = 1'b1;
                    end else begin
                        turn_d = (turn == TURN_P1) ? TURN_P2 : TURN_P1;
                    end
                end else begin
                    corr_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            step        <= 4'd0;
            turn        <= TURN_P1;
            sum         <= 8'd0;
            correctness <= 1'b1;
            game_over   <= 1'b0;
        end else begin
            step        <= step_d;
            turn        <= turn_d;
            sum         <= sum_d;
            correctness <= corr_d;
            game_over   <= over_d;
        end
    end

endmodule

// File: tb/tb_race_game_ctrl.sv
// tb_race_game_ctrl
//   Self-checking bench for race_game_ctrl with a short debounce window.
//   A behavioural game model runs alongside the DUT and is compared on
//   every falling edge; directed literal expectations pin the model.
module tb_race_game_ctrl;

    localparam int D    = 4;
    localparam int TGT  = 100;
    localparam int MAXS = 9;

    logic       clk;
    logic       reset;
    logic       btn;
    logic [3:0] sw;
    logic [3:0] turn;
    logic [7:0] sum;
    logic       correctness;
    logic       game_over;

    int checks = 0;
    int errors = 0;

    race_game_ctrl #(
        .TARGET         (TGT),
        .MAX_STEP       (MAXS),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn        (btn),
        .sw         (sw),
        .turn       (turn),
        .sum        (sum),
        .correctness(correctness),
        .game_over  (game_over)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Button: the controller sees btn two samples late; a new level is
    // believed after D consecutive differing samples; a rising belief is a
    // press. A press starts an evaluation applied one cycle later.
    int m_sum, m_turn, m_corr, m_over;
    int hist [0:1];
    int clean, run, press_f, pend, pend_step, acc;
    bit m_ready = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_sum = 0; m_turn = 1; m_corr = 1; m_over = 0;
            hist[0] = 0; hist[1] = 0;
            clean = 0; run = 0; press_f = 0; pend = 0; pend_step = 0;
            m_ready = 1'b1;
        end else begin
            if (pend != 0) begin
                if (pend_step >= 1 && pend_step <= MAXS && m_sum + pend_step <= TGT) begin
                    m_sum  = m_sum + pend_step;
                    m_corr = 1;
                    if (m_sum == TGT) m_over = 1;
                    else              m_turn = 3 - m_turn;
                end else begin
                    m_corr = 0;
                end
                pend = 0;
            end else if (press_f != 0 && m_over == 0) begin
                pend      = 1;
                pend_step = int'(sw);
            end
            acc = 0;
            if (hist[1] != clean) begin
                run++;
                if (run == D) begin
                    clean = hist[1];
                    run   = 0;
                    acc   = clean;
                end
            end else begin
                run = 0;
            end
            press_f = acc;
            hist[1] = hist[0];
            hist[0] = int'(btn);
        end
    end

    always @(negedge clk) begin
        if (m_ready) begin
            check("turn",        int'(turn),        m_turn);
            check("sum",         int'(sum),         m_sum);
            check("correctness", int'(correctness), m_corr);
            check("game_over",   int'(game_over),   m_over);
            check("turn_legal",  int'(turn == 4'd1 || turn == 4'd2), 1);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic expect_outs(input string name, input int t, input int s,
                               input int c, input int g);
        check({name, ".turn"},        int'(turn),        t);
        check({name, ".sum"},         int'(sum),         s);
        check({name, ".correctness"}, int'(correctness), c);
        check({name, ".game_over"},   int'(game_over),   g);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic press_step(input int v, input int hold = 12, input int bounce = 0);
        sw = 4'(v);
        repeat (bounce) begin
            btn = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        btn = 1'b1;
        repeat (hold) @(negedge clk);
        btn = 1'b0;
        repeat (14) @(negedge clk);
    endtask

    int pc, uc;
    bit seen;

    initial begin
        reset = 1'b1;
        btn   = 1'b0;
        sw    = 4'd0;
        repeat (2) @(negedge clk);
        expect_outs("reset", 1, 0, 1, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        expect_outs("idle", 1, 0, 1, 0);

        // bounce filtering and press-to-update latency
        sw = 4'd5;
        for (int i = 0; i < 10; i++) begin
            btn = ~btn;
            @(negedge clk);
        end
        pc = -1;
        uc = -1;
        for (int i = 0; i < 24; i++) begin
            btn = (i < 8);
            @(negedge clk);
            if (dut.u_deb.press_out && pc < 0) pc = i;
            if (sum != 8'd0 && uc < 0) uc = i;
        end
        check("bounce_press_seen", int'(pc >= 0), 1);
        check("bounce_latency", uc - pc, 2);
        expect_outs("bounce", 2, 5, 1, 0);

        // reset in the cycle after a press pulse
        do_reset();
        sw   = 4'd7;
        btn  = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (dut.u_deb.press_out) seen = 1'b1;
        end
        check("rst_press_seen", int'(seen), 1);
        reset = 1'b1;
        btn   = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        expect_outs("reset_after_press", 1, 0, 1, 0);

        // alternating turns
        press_step(7); expect_outs("step7", 2, 7, 1, 0);
        press_step(3); expect_outs("step3", 1, 10, 1, 0);
        press_step(9); expect_outs("step9", 2, 19, 1, 0);

        // invalid steps
        press_step(0);  expect_outs("sw0",  2, 19, 0, 0);
        press_step(12); expect_outs("sw12", 2, 19, 0, 0);
        press_step(4);  expect_outs("sw4",  1, 23, 1, 0);

        // overshoot and exact hit
        repeat (8) press_step(9);
        expect_outs("reach95", 1, 95, 1, 0);
        press_step(8); expect_outs("overshoot", 1, 95, 0, 0);
        press_step(5); expect_outs("win", 1, 100, 1, 1);
        press_step(3); expect_outs("frozen1", 1, 100, 1, 1);
        press_step(3); expect_outs("frozen2", 1, 100, 1, 1);

        // held button
        do_reset();
        sw  = 4'd2;
        btn = 1'b1;
        repeat (50) @(negedge clk);
        expect_outs("held", 2, 2, 1, 0);
        btn = 1'b0;
        repeat (20) @(negedge clk);
        expect_outs("released", 2, 2, 1, 0);

        // randomized games against the model
        for (int g = 0; g < 2; g++) begin
            do_reset();
            for (int i = 0; i < 80 && !game_over; i++) begin
                press_step($urandom_range(0, 15), $urandom_range(8, 14), $urandom_range(0, 6));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
